modulator_scheduler: RTL and testbench

Shares the single PAM modulator's FIFO-read interface between two byte-stream sources, such as the host sample FIFO and the test-pattern FIFO. The block locks a grant for one complete modulator frame of `FRAME_BYTES` reads, so both bytes of a sample always come from the same source. Between frames it arbitrates round-robin or with strict priority, and it counts underruns and stalled frames. It sits between the source FIFOs and the modulator's `sample`/`empty`/`read` ports.

---
 rtl/modulator_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 42 ++++
 rtl/modulator_scheduler.sv | 167 ++++++++++++++++
 tb/tb_modulator_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/modulator_pkg.sv
// Shared state encodings and grant constants for the modulator source scheduler.
// Pure declarations: no latency, no flow control.
// Imported by modulator_scheduler and rr_arbiter2.
package modulator_pkg;

    typedef enum logic [1:0] {
        ST_SCHED_IDLE    = 2'd0,
        ST_SCHED_ARB     = 2'd1,
        ST_SCHED_LOCKED  = 2'd2,
        ST_SCHED_RELEASE = 2'd3
    } sched_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_SRC0 = 2'b01;
    localparam logic [1:0] GRANT_SRC1 = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter: strict src0 priority or round-robin on a last-granted pointer.
// Grant is combinational from req; pointer updates on the edge where update is high.
// No backpressure; the caller decides when a grant is taken.
module rr_arbiter2 import modulator_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       prio_mode,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_src1_q;
    logic last_src1_d;

    always_comb begin
        gnt = GRANT_NONE;
        case (req)
            2'b01:   gnt = GRANT_SRC0;
            2'b10:   gnt = GRANT_SRC1;
            2'b11:   gnt = (prio_mode || last_src1_q) ? GRANT_SRC0 : GRANT_SRC1;
            default: gnt = GRANT_NONE;
        endcase
    end

    always_comb begin
        last_src1_d = last_src1_q;
        if (update && (gnt != GRANT_NONE)) begin
            last_src1_d = gnt[1];
        end
    end

    // Reset points at src1 so src0 takes the first round-robin tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_src1_q <= 1'b1;
        end else begin
            last_src1_q <= last_src1_d;
        end
    end

endmodule

// File: rtl/modulator_scheduler.sv
// Locks one of two byte sources onto the modulator FIFO port for a full frame.
// Grant 1 cycle after ARB; reads/data pass through combinationally. Optional MODULATOR_SCHED_STATS_EN.
// Backpressure: modulator sees mod_empty=1 outside LOCKED or when the granted source is empty.
module modulator_scheduler import modulator_pkg::*; #(
    parameter int FRAME_BYTES  = 2,
    parameter int IDLE_TIMEOUT = 2400,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 prio_mode,
    input  logic [7:0]           src0_sample,
    input  logic                 src0_empty,
    output logic                 src0_read,
    input  logic [7:0]           src1_sample,
    input  logic                 src1_empty,
    output logic                 src1_read,
    output logic [7:0]           mod_sample,
    output logic                 mod_empty,
    input  logic                 mod_read,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] underrun_count
);

    localparam int RD_W = $clog2(FRAME_BYTES + 1);
    localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(FRAME_BYTES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(IDLE_TIMEOUT - 1);

    sched_state_e    state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [RD_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       arb_update;
    logic       locked;
    logic       accepted;
    logic       granted_empty;
    logic       frame_done;
    logic       timeout_hit;

    assign arb_req    = {~src1_empty, ~src0_empty};
    assign arb_update = (state_q == ST_SCHED_ARB) && enable && (arb_gnt != GRANT_NONE);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (arb_req),
        .prio_mode (prio_mode),
        .update    (arb_update),
        .gnt       (arb_gnt)
    );

    assign locked        = (state_q == ST_SCHED_LOCKED);
    assign src0_read     = mod_read & grant_q[0] & ~src0_empty & locked;
    assign src1_read     = mod_read & grant_q[1] & ~src1_empty & locked;
    assign accepted      = src0_read | src1_read;
    assign granted_empty = grant_q[1] ? src1_empty : src0_empty;

    // A read in the final timeout cycle wins: the frame completes instead of aborting.
    assign frame_done  = accepted && (rd_cnt_q == RD_LAST);
    assign timeout_hit = locked && !accepted && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rd_cnt_d = rd_cnt_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            ST_SCHED_IDLE: begin
                grant_d = GRANT_NONE;
                if (enable) begin
                    state_d = ST_SCHED_ARB;
                end
            end
            ST_SCHED_ARB: begin
                grant_d = GRANT_NONE;
                if (!enable) begin
                    state_d = ST_SCHED_IDLE;
                end else if (arb_gnt != GRANT_NONE) begin
                    grant_d  = arb_gnt;
                    rd_cnt_d = '0;
                    to_cnt_d = '0;
                    state_d  = ST_SCHED_LOCKED;
                end
            end
            ST_SCHED_LOCKED: begin
                if (accepted) begin
                    rd_cnt_d = rd_cnt_q + RD_W'(1);
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
                if (frame_done || timeout_hit) begin
                    state_d = ST_SCHED_RELEASE;
                end
            end
            ST_SCHED_RELEASE: begin
                grant_d = GRANT_NONE;
                state_d = enable ? ST_SCHED_ARB : ST_SCHED_IDLE;
            end
            default: begin
                grant_d = GRANT_NONE;
                state_d = ST_SCHED_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SCHED_IDLE;
            grant_q  <= GRANT_NONE;
            rd_cnt_q <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rd_cnt_q <= rd_cnt_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Grant stays held through RELEASE so the last byte is still on the mux.
    always_comb begin
        mod_sample = 8'h00;
        case (grant_q)
            GRANT_SRC0: mod_sample = src0_sample;
            GRANT_SRC1: mod_sample = src1_sample;
            default:    mod_sample = 8'h00;
        endcase
    end

    assign mod_empty = locked ? granted_empty : 1'b1;
    assign grant     = grant_q;
    assign busy      = locked || (state_q == ST_SCHED_RELEASE);

`ifdef MODULATOR_SCHED_STATS_EN
    logic [CNT_WIDTH-1:0] uc_q, uc_d;
    logic                 uc_event;

    // Underrun and timeout in the same cycle count once.
    always_comb begin
        uc_event = (locked && mod_read && granted_empty) || timeout_hit;
        uc_d     = uc_q;
        if (uc_event && (uc_q != {CNT_WIDTH{1'b1}})) begin
            uc_d = uc_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uc_q <= '0;
        end else begin
            uc_q <= uc_d;
        end
    end

    assign underrun_count = uc_q;
`else
    assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_modulator_scheduler.sv
// Directed, table-driven bench for modulator_scheduler (FRAME_BYTES=2, IDLE_TIMEOUT=8).
// Inputs change just after the rising edge; outputs are compared on the falling edge.
module tb_modulator_scheduler;

`ifdef MODULATOR_SCHED_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, enable, prio_mode;
    logic [7:0]  src0_sample, src1_sample, mod_sample;
    logic        src0_empty, src1_empty, src0_read, src1_read;
    logic        mod_empty, mod_read, busy;
    logic [1:0]  grant;
    logic [15:0] underrun_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    modulator_scheduler #(
        .FRAME_BYTES  (2),
        .IDLE_TIMEOUT (8),
        .CNT_WIDTH    (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .prio_mode      (prio_mode),
        .src0_sample    (src0_sample),
        .src0_empty     (src0_empty),
        .src0_read      (src0_read),
        .src1_sample    (src1_sample),
        .src1_empty     (src1_empty),
        .src1_read      (src1_read),
        .mod_sample     (mod_sample),
        .mod_empty      (mod_empty),
        .mod_read       (mod_read),
        .grant          (grant),
        .busy           (busy),
        .underrun_count (underrun_count)
    );

    typedef struct {
        logic       r, e, p, e0, e1, mr;
        logic [1:0] g;
        logic       b, me, r0, r1;
        logic [7:0] smp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, e, p, e0, e1, mr);
        rst        = r;
        enable     = e;
        prio_mode  = p;
        src0_empty = e0;
        src1_empty = e1;
        mod_read   = mr;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, e, p, e0, e1, mr,
                                input logic [1:0] g, input logic b, me, r0, r1,
                                input logic [7:0] smp);
        vec_t v;
        v.r = r; v.e = e; v.p = p; v.e0 = e0; v.e1 = e1; v.mr = mr;
        v.g = g; v.b = b; v.me = me; v.r0 = r0; v.r1 = r1; v.smp = smp;
        return v;
    endfunction

    // One frame with both sources full: ARB, two accepted reads, RELEASE.
    task automatic add_frame(input logic p, input logic en_rel, input logic [1:0] g);
        logic [7:0] smp;
        smp = (g == 2'b01) ? 8'hA5 : 8'h3C;
        tbl.push_back(mk(0, 1, p, 0, 0, 0, 2'b00, 0, 1, 0, 0, 8'h00));
        repeat (2) tbl.push_back(mk(0, 1, p, 0, 0, 1, g, 1, 0, g[0], g[1], smp));
        tbl.push_back(mk(0, en_rel, p, 0, 0, 0, g, 1, 1, 0, 0, smp));
    endtask

    initial begin
        src0_sample = 8'hA5;
        src1_sample = 8'h3C;
        rst = 1'b1; enable = 1'b0; prio_mode = 1'b0;
        src0_empty = 1'b1; src1_empty = 1'b1; mod_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then a src0-only frame.
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 2'b00, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 2'b00, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 2'b00, 0, 1, 0, 0, 8'h00));
        repeat (2) tbl.push_back(mk(0, 1, 0, 0, 1, 1, 2'b01, 1, 0, 1, 0, 8'hA5));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 2'b01, 1, 1, 0, 0, 8'hA5));
        // Nothing eligible: ARB holds without granting.
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 2'b00, 0, 1, 0, 0, 8'h00));
        // Round-robin, src0 was last granted.
        add_frame(0, 1, 2'b10);
        add_frame(0, 1, 2'b01);
        add_frame(0, 1, 2'b10);
        add_frame(0, 1, 2'b01);
        // Strict priority: src0 every time, even though src1 is next in rotation.
        add_frame(1, 1, 2'b01);
        add_frame(1, 1, 2'b01);
        add_frame(1, 0, 2'b01);
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].p, tbl[i].e0, tbl[i].e1, tbl[i].mr);
            chk($sformatf("vec%0d.grant", i),     32'(grant),      32'(tbl[i].g));
            chk($sformatf("vec%0d.busy", i),      32'(busy),       32'(tbl[i].b));
            chk($sformatf("vec%0d.mod_empty", i), 32'(mod_empty),  32'(tbl[i].me));
            chk($sformatf("vec%0d.src0_read", i), 32'(src0_read),  32'(tbl[i].r0));
            chk($sformatf("vec%0d.src1_read", i), 32'(src1_read),  32'(tbl[i].r1));
            chk($sformatf("vec%0d.mod_sample", i), 32'(mod_sample), 32'(tbl[i].smp));
            chk($sformatf("vec%0d.underrun", i),  32'(underrun_count), 32'd0);
            adv();
        end

        // Underrun: src0 drains after the first read, then refills.
        drive(0, 1, 0, 0, 1, 0); adv();
        drive(0, 1, 0, 0, 1, 0); adv();
        drive(0, 1, 0, 0, 1, 1);
        chk("ur.first_read", 32'(src0_read), 32'd1);
        adv();
        drive(0, 1, 0, 1, 1, 1);
        chk("ur.read_blocked", 32'(src0_read), 32'd0);
        chk("ur.mod_empty",    32'(mod_empty), 32'd1);
        chk("ur.grant_held",   32'(grant),     32'd1);
        adv();
        drive(0, 1, 0, 0, 1, 1);
        chk("ur.count",       32'(underrun_count), 32'(STATS));
        chk("ur.second_read", 32'(src0_read),      32'd1);
        chk("ur.grant_held2", 32'(grant),          32'd1);
        adv();
        drive(0, 0, 0, 0, 1, 0);
        chk("ur.release_grant", 32'(grant), 32'd1);
        chk("ur.release_busy",  32'(busy),  32'd1);
        adv();

        // Timeout: 8 locked cycles with no read; enable drops but must not abort.
        drive(1, 0, 0, 0, 1, 0); adv();
        drive(0, 1, 0, 0, 1, 0);
        chk("to.reset_count", 32'(underrun_count), 32'd0);
        adv();
        drive(0, 1, 0, 0, 1, 0); adv();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 1, 0);
            chk($sformatf("to.lock%0d.mod_empty", i), 32'(mod_empty),      32'd0);
            chk($sformatf("to.lock%0d.count", i),     32'(underrun_count), 32'd0);
            adv();
        end
        drive(0, 0, 0, 0, 1, 0);
        chk("to.release_busy",      32'(busy),           32'd1);
        chk("to.release_mod_empty", 32'(mod_empty),      32'd1);
        chk("to.count",             32'(underrun_count), 32'(STATS));
        adv();
        drive(0, 0, 0, 0, 1, 0);
        chk("to.idle_busy",  32'(busy),  32'd0);
        chk("to.idle_grant", 32'(grant), 32'd0);
        adv();

        // Reset in the middle of a frame, with an underrun pending on that edge.
        drive(0, 1, 0, 0, 1, 0); adv();
        drive(0, 1, 0, 0, 1, 0); adv();
        drive(0, 1, 0, 0, 1, 1);
        chk("rst.pre_read", 32'(src0_read), 32'd1);
        adv();
        drive(1, 1, 0, 1, 1, 1);
        chk("rst.pre_grant", 32'(grant), 32'd1);
        adv();
        drive(0, 0, 0, 0, 1, 1);
        chk("rst.grant",      32'(grant),          32'd0);
        chk("rst.mod_empty",  32'(mod_empty),      32'd1);
        chk("rst.count",      32'(underrun_count), 32'd0);
        chk("rst.busy",       32'(busy),           32'd0);
        chk("rst.src0_read",  32'(src0_read),      32'd0);
        chk("rst.mod_sample", 32'(mod_sample),     32'd0);
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
